// File: rtl/puf_resp_collector.sv
`default_nettype none
// ============================================================================
// Module      : puf_resp_collector
// Description : Ring-oscillator PUF response collector. For each of 8 bits it
//               clears the bank counters, enables the oscillators for WINDOW
//               cycles, waits SETTLE cycles, then compares bank A against
//               bank B. The 8 compare results form one response byte.
//               Optional feature macro: PUF_TIE_FLAG_EN adds a tie_cnt output
//               counting compares where both counts were equal.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_resp_collector #(
  parameter int WINDOW = 64,  // osc_en high cycles per bit, 1..1023
  parameter int SETTLE = 2    // quiet cycles before compare, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,      // active-high asynchronous reset
  input  logic       start,
  input  logic [4:0] chal_base,
  input  logic [7:0] cnt_a,
  input  logic [7:0] cnt_b,
  output logic       osc_en,
  output logic       cnt_clr,
  output logic [4:0] challenge,
  output logic [7:0] response,
  output logic       valid,
  output logic       busy
`ifdef PUF_TIE_FLAG_EN
  ,
  output logic [3:0] tie_cnt
`endif
);

  // Timer reload values: the timer counts down to zero, so a load of N-1
  // gives a phase of exactly N cycles.
  localparam logic [9:0] c_WIN_LAST = 10'(WINDOW - 1);
  localparam logic [9:0] c_SET_LAST = 10'(SETTLE - 1);
  localparam logic [2:0] c_LAST_BIT = 3'd7;

  // Elaboration-time guard on the legal parameter ranges.
  if (WINDOW < 1 || WINDOW > 1023) begin : g_bad_window
    $error("puf_resp_collector: WINDOW must be in 1..1023");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("puf_resp_collector: SETTLE must be in 1..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;      // bit currently being measured
  logic [4:0] r_base;     // challenge captured at start
  logic [9:0] r_tmr;      // shared MEASURE / SETTLE down-counter
  logic [7:0] r_shift;    // response under construction
  logic [7:0] r_resp;     // last completed response
  logic       r_osc_en;
  logic       r_cnt_clr;
  logic [4:0] r_chal;
  logic       r_valid;
  logic       r_busy;
`ifdef PUF_TIE_FLAG_EN
  logic [3:0] r_tie;
`endif

  logic       w_bit;
  logic       w_tie;
  logic [7:0] w_shift_in;
  logic [4:0] w_next_chal;

  // The counts are only meaningful in COMPARE; SETTLE has let them go quiet.
  assign w_bit       = (cnt_a > cnt_b);
  assign w_tie       = (cnt_a == cnt_b);
  // Shifting in at the MSB means the first bit ends up at response[0].
  assign w_shift_in  = {w_bit, r_shift[7:1]};
  // 5-bit addition wraps 31 -> 0 naturally.
  assign w_next_chal = r_base + {2'b00, r_idx} + 5'd1;

  // Collection FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_base    <= 5'd0;
      r_tmr     <= 10'd0;
      r_shift   <= 8'h00;
      r_resp    <= 8'h00;
      r_osc_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_chal    <= 5'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef PUF_TIE_FLAG_EN
      r_tie     <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base    <= chal_base;
            r_chal    <= chal_base;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_cnt_clr <= 1'b1;
            r_busy    <= 1'b1;
`ifdef PUF_TIE_FLAG_EN
            r_tie     <= 4'd0;
`endif
            r_state   <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          r_cnt_clr <= 1'b0;
          r_osc_en  <= 1'b1;
          r_tmr     <= c_WIN_LAST;
          r_state   <= ST_MEASURE;
        end

        ST_MEASURE: begin
          if (r_tmr == 10'd0) begin
            r_osc_en <= 1'b0;
            r_tmr    <= c_SET_LAST;
            r_state  <= ST_SETTLE;
          end else begin
            r_tmr <= r_tmr - 10'd1;
          end
        end

        ST_SETTLE: begin
          if (r_tmr == 10'd0) begin
            r_state <= ST_COMPARE;
          end else begin
            r_tmr <= r_tmr - 10'd1;
          end
        end

        ST_COMPARE: begin
          r_shift <= w_shift_in;
`ifdef PUF_TIE_FLAG_EN
          if (w_tie) begin
            r_tie <= r_tie + 4'd1;
          end
`endif
          if (r_idx == c_LAST_BIT) begin
            r_resp  <= w_shift_in;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx     <= r_idx + 3'd1;
            r_chal    <= w_next_chal;
            r_cnt_clr <= 1'b1;
            r_state   <= ST_CLEAR;
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here.
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_osc_en  <= 1'b0;
          r_cnt_clr <= 1'b0;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef PUF_TIE_FLAG_EN
  // Tie detection only feeds the optional counter.
  logic w_unused;
  assign w_unused = w_tie;
`endif

  assign osc_en    = r_osc_en;
  assign cnt_clr   = r_cnt_clr;
  assign challenge = r_chal;
  assign response  = r_resp;
  assign valid     = r_valid;
  assign busy      = r_busy;
`ifdef PUF_TIE_FLAG_EN
  assign tie_cnt   = r_tie;
`endif

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_resp_collector
// Description : Self-checking bench for puf_resp_collector. Table vectors and
//               random collections are checked cycle by cycle against a
//               timing model derived from the per-bit period; a second
//               instance covers WINDOW=1, SETTLE=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_resp_collector;

  localparam int W  = 64;
  localparam int S  = 2;
  localparam int P  = W + S + 2;   // cycles per bit
  localparam int NB = 8 * P + 1;   // cycle number of the DONE/valid cycle

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic [4:0] chal_base;
  logic [7:0] cnt_a, cnt_b;
  logic [7:0] cnt_a2, cnt_b2;
  logic       osc_en, cnt_clr, valid, busy;
  logic [4:0] challenge;
  logic [7:0] response;
  logic       osc_en2, cnt_clr2, valid2, busy2;
  logic [4:0] challenge2;
  logic [7:0] response2;
`ifdef PUF_TIE_FLAG_EN
  logic [3:0] tie_cnt, tie_cnt2;
`endif

  always #5 clk = ~clk;

  puf_resp_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
    .challenge(challenge), .response(response), .valid(valid), .busy(busy)
`ifdef PUF_TIE_FLAG_EN
    , .tie_cnt(tie_cnt)
`endif
  );

  puf_resp_collector #(.WINDOW(1), .SETTLE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start2), .chal_base(5'd9),
    .cnt_a(cnt_a2), .cnt_b(cnt_b2), .osc_en(osc_en2), .cnt_clr(cnt_clr2),
    .challenge(challenge2), .response(response2), .valid(valid2), .busy(busy2)
`ifdef PUF_TIE_FLAG_EN
    , .tie_cnt(tie_cnt2)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]      base;
    logic [7:0][7:0] av;    // cnt_a for bit i at av[i]
    logic [7:0][7:0] bv;
    logic [7:0]      resp;
    logic [3:0]      tie;
    int              kick;  // 1: pulse start at bit 3 and in DONE
  } vec_t;

  vec_t tbl[5];

  // One collection with every cycle checked against the period model.
  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_coll(input logic [4:0] base, input logic [7:0][7:0] av,
                          input logic [7:0][7:0] bv, input logic [7:0] er,
                          input logic [3:0] et, input int kick);
    logic [8:0] exp_o;
    int bitn, ph;
    chk("idle_before_start", 0, 32'(busy), 32'd0);
    start     = 1'b1;
    chal_base = base;
    @(posedge clk); #1;
    start     = 1'b0;
    chal_base = 5'($urandom);
    for (int c = 1; c <= NB + 1; c++) begin
      bitn = (c - 1) / P;
      ph   = (c - 1) % P;
      if (c < NB) begin
        exp_o = {1'b1, 1'b0, logic'(ph >= 1 && ph <= W), logic'(ph == 0), 5'(base + bitn)};
        chk("outputs", c, 32'({busy, valid, osc_en, cnt_clr, challenge}), 32'(exp_o));
      end else if (c == NB) begin
        chk("done_flags", c, 32'({busy, valid, osc_en, cnt_clr}), 32'b1100);
        chk("response", c, 32'(response), 32'(er));
`ifdef PUF_TIE_FLAG_EN
        chk("tie_cnt", c, 32'(tie_cnt), 32'(et));
`endif
      end else begin
        chk("idle_flags", c, 32'({busy, valid, osc_en, cnt_clr}), 32'b0000);
        chk("response_hold", c, 32'(response), 32'(er));
      end
      if (c < NB && ph == P - 1) begin
        cnt_a = av[bitn];
        cnt_b = bv[bitn];
      end else begin
        cnt_a = 8'($urandom);
        cnt_b = 8'($urandom);
      end
      start = (kick != 0) && (c == 3 * P + 5 || c == NB);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("no_restart", NB + 2, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]      rb;
    logic [7:0][7:0] ra, rbv;
    logic [7:0]      rr;
    logic [3:0]      rt;
    int vc, oc;

    tbl[0] = '{5'd3,  {8{8'h50}}, {8{8'h40}}, 8'hFF, 4'd0, 0};
    tbl[1] = '{5'd30, {8'h10, 8'h90, 8'h10, 8'h90, 8'h10, 8'h90, 8'h10, 8'h90},
                      {8{8'h40}}, 8'h55, 4'd0, 0};
    tbl[2] = '{5'd12, {8{8'h80}}, {8{8'h80}}, 8'h00, 4'd8, 0};
    tbl[3] = '{5'd17, {8'h33, 8'hFE, 8'h00, 8'h01, 8'h80, 8'h7F, 8'hFF, 8'h00},
                      {8'h32, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'h01},
                      8'h8A, 4'd2, 0};
    tbl[4] = '{5'd31, {8{8'hC3}}, {8{8'h3C}}, 8'hFF, 4'd0, 1};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; chal_base = 5'd0;
    cnt_a = 8'h00; cnt_b = 8'h00; cnt_a2 = 8'h50; cnt_b2 = 8'h40;
    #2 rst_n = 1'b1;
    #1;
    chk("reset_async", 0, 32'({busy, valid, osc_en, cnt_clr, challenge, response}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_held", 0, 32'({busy, valid, osc_en, cnt_clr, challenge, response}), 32'd0);
`ifdef PUF_TIE_FLAG_EN
    chk("reset_tie", 0, 32'(tie_cnt), 32'd0);
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++)
      run_coll(tbl[v].base, tbl[v].av, tbl[v].bv, tbl[v].resp, tbl[v].tie, tbl[v].kick);

    // Random collections; expected response from the plain compare rule.
    for (int n = 0; n < 5; n++) begin
      rb = 5'($urandom);
      rr = 8'h00;
      rt = 4'd0;
      for (int i = 0; i < 8; i++) begin
        ra[i]  = 8'($urandom);
        rbv[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 8'($urandom);
        if (ra[i] > rbv[i]) rr = rr | (8'h01 << i);
        if (ra[i] == rbv[i]) rt = rt + 4'd1;
      end
      run_coll(rb, ra, rbv, rr, rt, 0);
    end

    // Abort during MEASURE of bit 5; last response before this was nonzero.
    run_coll(5'd7, {8{8'hFF}}, {8{8'h00}}, 8'hFF, 4'd0, 0);
    start = 1'b1; chal_base = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 5 * P + 10; c++) begin
      cnt_a = 8'($urandom); cnt_b = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("bit5_measuring", 5 * P + 10, 32'({osc_en, challenge}), 32'({1'b1, 5'd25}));
    #2 rst_n = 1'b1;
    #1;
    chk("abort_async", 0, 32'({busy, valid, osc_en, cnt_clr, challenge, response}), 32'd0);
    vc = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (valid) vc++;
    end
    chk("abort_no_valid", 0, 32'(vc), 32'd0);
    rst_n = 1'b0;
    run_coll(5'd0, {8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00},
             {8{8'h00}}, 8'hAA, 4'd4, 0);

    // Minimum timing instance: WINDOW=1, SETTLE=1 gives valid at cycle 33.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    vc = -1;
    oc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (osc_en2) oc++;
      if (valid2) begin
        vc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("min_valid_cycle", 0, 32'(vc), 32'd33);
    chk("min_osc_cycles", 0, 32'(oc), 32'd8);
    chk("min_response", 0, 32'(response2), 32'hFF);
    @(posedge clk); #1;
    chk("min_idle", 0, 32'({busy2, valid2}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puf_resp_collector.md
PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

Interface
REQ-001 Parameter WINDOW, default 64: clock cycles osc_en is held high per measurement, legal range 1..1023.
REQ-002 Parameter SETTLE, default 2: clock cycles after osc_en falls before the counts are sampled, legal range 1..15.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-high reset (the port name is kept for codebase consistency; a high level resets).
REQ-005 start  input  1  request one 8-bit response; sampled only in IDLE.
REQ-006 chal_base  input  5  base challenge, captured when start is accepted.
REQ-007 cnt_a  input  8  count from oscillator bank A counter.
REQ-008 cnt_b  input  8  count from oscillator bank B counter.
REQ-009 osc_en  output  1  enable to both oscillator banks.
REQ-010 cnt_clr  output  1  clear pulse to both counters.
REQ-011 challenge  output  5  oscillator select applied to both banks.
REQ-012 response  output  8  collected response.
REQ-013 valid  output  1  one-cycle pulse when response is complete.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM states are IDLE, CLEAR, MEASURE, SETTLE, COMPARE and DONE.
REQ-016 IDLE with start=1: capture chal_base, set bit index i=0, clear the response shift register, go to CLEAR; start=0 stays in IDLE.
REQ-017 CLEAR lasts 1 cycle with cnt_clr=1 and osc_en=0, then goes to MEASURE.
REQ-018 MEASURE holds osc_en=1 for exactly WINDOW cycles, then goes to SETTLE.
REQ-019 SETTLE holds osc_en=0 for exactly SETTLE cycles, then goes to COMPARE.
REQ-020 COMPARE lasts 1 cycle: bit = (cnt_a > cnt_b), unsigned 8-bit compare; the bit shifts into response LSB-first so bit i lands at response[i].
REQ-021 After COMPARE: if i<7, increment i and go to CLEAR; if i=7, go to DONE.
REQ-022 DONE lasts 1 cycle with valid=1, then goes to IDLE.
REQ-023 challenge = (captured chal_base + i) mod 32 and is held stable from CLEAR through COMPARE of bit i; it wraps from 31 to 0.
REQ-024 Tie (cnt_a == cnt_b) yields bit 0.
REQ-025 Per-bit period = WINDOW+SETTLE+2 cycles; valid asserts exactly 8*(WINDOW+SETTLE+2)+1 cycles after the edge that accepted start (545 with the defaults).
REQ-026 response holds its last completed value from DONE until the next accepted start; it does not update during a collection.
REQ-027 start while busy=1 is ignored and does not queue; start asserted in the DONE cycle is also ignored.
REQ-028 cnt_a and cnt_b are used only in COMPARE; they are not registered or synchronised elsewhere (SETTLE covers counter settling).
REQ-029 osc_en=1 only in MEASURE, and cnt_clr=1 only in CLEAR.

Reset
REQ-030 rst_n=1 forces, asynchronously: state IDLE, i=0, captured challenge 0, response 0x00, valid 0, busy 0, osc_en 0, cnt_clr 0, challenge 0.
REQ-031 Reset mid-collection aborts with no valid pulse; the partial response is discarded (response reads 0x00).
REQ-032 After rst_n falls, the first start is accepted on the next rising clk edge.

Configuration
REQ-033 With macro PUF_TIE_FLAG_EN defined: add output tie_cnt (4 bits), cleared on accepted start and on reset, incremented in each COMPARE where cnt_a == cnt_b, and valid alongside response with range 0..8.
REQ-034 With PUF_TIE_FLAG_EN undefined: the tie_cnt port and its logic are absent, and all other behaviour is identical.

Verification
REQ-035 Defaults, chal_base=3, cnt_a=0x50, cnt_b=0x40 fixed, start 1 cycle -> challenge steps 3..10, valid pulses at cycle 545, response=0xFF.
REQ-036 chal_base=30, cnt_a>cnt_b for even i only -> challenge sequence 30,31,0,1,2,3,4,5; response=0x55.
REQ-037 cnt_a==cnt_b=0x80 for all bits -> response=0x00; with PUF_TIE_FLAG_EN, tie_cnt=8.
REQ-038 start pulsed again at bit 3 and in the DONE cycle -> no restart, a single valid pulse, busy held throughout.
REQ-039 rst_n=1 during MEASURE of bit 5 -> osc_en drops immediately, no valid pulse, response=0x00, next start runs a full 545-cycle collection.
REQ-040 WINDOW=1, SETTLE=1 -> osc_en high exactly 1 cycle per bit, valid at cycle 33.
